// File: rtl/peripheral_gpio_debounce_pkg.sv
// rtl/peripheral_gpio_debounce_pkg.sv - shared debounce types; SYNC_STAGES set by PERIPHERAL_GPIO_DEBOUNCE_SYNC3_EN
package peripheral_gpio_debounce_pkg;

`ifdef PERIPHERAL_GPIO_DEBOUNCE_SYNC3_EN
    localparam int SYNC_STAGES = 3;
`else
    localparam int SYNC_STAGES = 2;
`endif

    localparam int DEFAULT_CNT_SIZE = 16;

    typedef enum logic {
        STABLE  = 1'b0,
        PENDING = 1'b1
    } dbnc_state_t;

endpackage

// File: rtl/peripheral_gpio_debounce_bit.sv
// rtl/peripheral_gpio_debounce_bit.sv - one-bit synchroniser, stability counter and edge pulses
module peripheral_gpio_debounce_bit
    import peripheral_gpio_debounce_pkg::*;
#(
    parameter int CNT_SIZE = DEFAULT_CNT_SIZE
) (
    input  logic                PCLK,
    input  logic                PRESET,
    input  logic                i_pad,
    input  logic [CNT_SIZE-1:0] i_threshold,
    output logic                o_level,
    output logic                o_rise,
    output logic                o_fall,
    output logic                o_pulse_nxt
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_level;
    logic                   r_rise;
    logic                   r_fall;
    logic [CNT_SIZE-1:0]    r_cnt;

    dbnc_state_t            w_state;
    logic                   w_sync;
    logic                   w_level_nxt;
    logic                   w_rise_nxt;
    logic                   w_fall_nxt;
    logic [CNT_SIZE-1:0]    w_cnt_nxt;

    assign w_sync = r_sync[SYNC_STAGES-1];

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_sync  <= '0;
            r_level <= 1'b0;
            r_cnt   <= '0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], i_pad};
            r_level <= w_level_nxt;
            r_cnt   <= w_cnt_nxt;
            r_rise  <= w_rise_nxt;
            r_fall  <= w_fall_nxt;
        end
    end

    // The state is implied by the synchronised pad disagreeing with the output level.
    always_comb begin
        w_state     = (w_sync != r_level) ? PENDING : STABLE;
        w_level_nxt = r_level;
        w_cnt_nxt   = '0;
        w_rise_nxt  = 1'b0;
        w_fall_nxt  = 1'b0;
        case (w_state)
            STABLE: w_cnt_nxt = '0;
            PENDING: begin
                if (r_cnt >= i_threshold) begin
                    w_level_nxt = w_sync;
                    w_rise_nxt  = w_sync;
                    w_fall_nxt  = ~w_sync;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_SIZE'(1);
                end
            end
            default: w_cnt_nxt = '0;
        endcase
    end

    assign o_level     = r_level;
    assign o_rise      = r_rise;
    assign o_fall      = r_fall;
    assign o_pulse_nxt = w_rise_nxt | w_fall_nxt;

endmodule

// File: rtl/peripheral_gpio_debounce.sv
// rtl/peripheral_gpio_debounce.sv - per-bit GPIO input debouncer; PERIPHERAL_GPIO_DEBOUNCE_SYNC3_EN selects 3-stage sync
module peripheral_gpio_debounce
    import peripheral_gpio_debounce_pkg::*;
#(
    parameter int PDATA_SIZE = 8,
    parameter int CNT_SIZE   = DEFAULT_CNT_SIZE
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic [PDATA_SIZE-1:0] pad_i,
    input  logic [CNT_SIZE-1:0]   threshold_i,
    output logic [PDATA_SIZE-1:0] gpio_o,
    output logic [PDATA_SIZE-1:0] rise_o,
    output logic [PDATA_SIZE-1:0] fall_o,
    output logic                  change_o
);

    logic [PDATA_SIZE-1:0] w_pulse_nxt;
    logic                  r_change;

    for (genvar g = 0; g < PDATA_SIZE; g++) begin : g_bit
        peripheral_gpio_debounce_bit #(
            .CNT_SIZE(CNT_SIZE)
        ) u_bit (
            .PCLK       (PCLK),
            .PRESET     (PRESET),
            .i_pad      (pad_i[g]),
            .i_threshold(threshold_i),
            .o_level    (gpio_o[g]),
            .o_rise     (rise_o[g]),
            .o_fall     (fall_o[g]),
            .o_pulse_nxt(w_pulse_nxt[g])
        );
    end

    // Built from the pulses' next values so change_o lines up with rise_o/fall_o.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_change <= 1'b0;
        end else begin
            r_change <= |w_pulse_nxt;
        end
    end

    assign change_o = r_change;

endmodule

// File: tb/tb_peripheral_gpio_debounce.sv
// tb/tb_peripheral_gpio_debounce.sv - self-checking bench for peripheral_gpio_debounce
module tb_peripheral_gpio_debounce;

`ifdef PERIPHERAL_GPIO_DEBOUNCE_SYNC3_EN
    localparam int S = 3;
`else
    localparam int S = 2;
`endif

    logic        PCLK = 1'b0;
    logic        PRESET = 1'b0;
    logic [7:0]  pad_i = '0;
    logic [15:0] threshold_i = '0;
    logic [7:0]  gpio_o;
    logic [7:0]  rise_o;
    logic [7:0]  fall_o;
    logic        change_o;

    peripheral_gpio_debounce #(
        .PDATA_SIZE(8),
        .CNT_SIZE  (16)
    ) dut (
        .PCLK       (PCLK),
        .PRESET     (PRESET),
        .pad_i      (pad_i),
        .threshold_i(threshold_i),
        .gpio_o     (gpio_o),
        .rise_o     (rise_o),
        .fall_o     (fall_o),
        .change_o   (change_o)
    );

    always #5 PCLK = ~PCLK;

    typedef struct packed {
        logic [7:0] gpio;
        logic [7:0] rise;
        logic [7:0] fall;
        logic       change;
    } exp_t;

    typedef struct {
        logic [7:0] pad;
        int         thr;
        exp_t       want;
    } vec_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad = 0;

    logic [7:0] m_sync [S];
    logic [7:0] m_gpio;
    int         m_cnt [8];

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, want, $time);
        end
    endtask

    task automatic model_step(input logic [7:0] pad, input int thr, input logic rst, output exp_t e);
        logic [7:0] sync;
        e = '0;
        if (rst) begin
            for (int i = 0; i < S; i++) m_sync[i] = '0;
            m_gpio = '0;
            for (int b = 0; b < 8; b++) m_cnt[b] = 0;
            return;
        end
        sync = m_sync[S-1];
        for (int b = 0; b < 8; b++) begin
            if (sync[b] != m_gpio[b]) begin
                if (m_cnt[b] >= thr) begin
                    m_gpio[b] = sync[b];
                    m_cnt[b]  = 0;
                    if (sync[b]) e.rise[b] = 1'b1;
                    else         e.fall[b] = 1'b1;
                end else begin
                    m_cnt[b]++;
                end
            end else begin
                m_cnt[b] = 0;
            end
        end
        for (int i = S - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
        m_sync[0] = pad;
        e.gpio   = m_gpio;
        e.change = |(e.rise | e.fall);
    endtask

    task automatic check_out();
        exp_t w;
        if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_underflow: got empty queue want entry at %0t", $time);
            return;
        end
        w = sb_q.pop_front();
        cmp("gpio_o", 32'(gpio_o), 32'(w.gpio));
        cmp("rise_o", 32'(rise_o), 32'(w.rise));
        cmp("fall_o", 32'(fall_o), 32'(w.fall));
        cmp("change_o", 32'(change_o), 32'(w.change));
    endtask

    task automatic drive(input logic [7:0] pad, input int thr, input logic rst,
                         input bit ovr, input exp_t oexp);
        exp_t e;
        pad_i       = pad;
        threshold_i = 16'(thr);
        PRESET      = rst;
        model_step(pad, thr, rst, e);
        sb_q.push_back(ovr ? oexp : e);
        @(posedge PCLK);
        #1;
        check_out();
        @(negedge PCLK);
    endtask

    task automatic run(input logic [7:0] pad, input int thr, input int n);
        for (int i = 0; i < n; i++) drive(pad, thr, 1'b0, 1'b0, '0);
    endtask

    initial begin
        vec_t tbl[10];
        int   idx;
        int   nr;
        int   nf;
        int   nc;
        logic [7:0] rv;

        // Reset release with T=4: pad all-high qualifies after edge S+5.
        for (int k = 0; k < 10; k++) begin
            tbl[k].pad        = 8'hFF;
            tbl[k].thr        = 4;
            tbl[k].want.gpio  = (k + 1 >= S + 5) ? 8'hFF : 8'h00;
            tbl[k].want.rise  = (k + 1 == S + 5) ? 8'hFF : 8'h00;
            tbl[k].want.fall  = 8'h00;
            tbl[k].want.change = (k + 1 == S + 5);
        end

        #1;
        PRESET = 1'b1;
        pad_i = 8'hFF;
        threshold_i = 16'd4;
        #1;
        cmp("rst_gpio", 32'(gpio_o), 32'h0);
        cmp("rst_rise", 32'(rise_o), 32'h0);
        cmp("rst_fall", 32'(fall_o), 32'h0);
        cmp("rst_change", 32'(change_o), 32'h0);
        @(negedge PCLK);
        for (int i = 0; i < 3; i++) drive(8'hFF, 4, 1'b1, 1'b0, '0);
        for (int k = 0; k < 10; k++) drive(tbl[k].pad, tbl[k].thr, 1'b0, 1'b1, tbl[k].want);

        // Glitch of 3 cycles against T=4 is rejected.
        run(8'h00, 4, 14);
        nr = 0;
        for (int i = 0; i < 3; i++) begin
            drive(8'h01, 4, 1'b0, 1'b0, '0);
            nr += int'(rise_o[0]);
        end
        for (int i = 0; i < 10; i++) begin
            drive(8'h00, 4, 1'b0, 1'b0, '0);
            nr += int'(rise_o[0]);
        end
        cmp("glitch_pulses", 32'(nr), 32'd0);
        cmp("glitch_gpio0", 32'(gpio_o[0]), 32'd0);
        cmp("glitch_cnt", 32'(dut.g_bit[0].u_bit.r_cnt), 32'd0);

        // Pass-through with T=0 on bit 3.
        idx = -1; nr = 0; nf = 0;
        for (int i = 0; i < 24; i++) begin
            drive(((i / 4) % 2) != 0 ? 8'h08 : 8'h00, 0, 1'b0, 1'b0, '0);
            if (rise_o[3] && idx < 0) idx = i;
            nr += int'(rise_o[3]);
            nf += int'(fall_o[3]);
        end
        cmp("pass_lag", 32'(idx), 32'(4 + S));
        cmp("pass_rises", 32'(nr), 32'd3);
        cmp("pass_falls", 32'(nf), 32'd2);

        // Lowering the threshold below the running count forces an update next edge.
        run(8'h0C, 100, S + 20);
        cmp("thr_cnt20", 32'(dut.g_bit[2].u_bit.r_cnt), 32'd20);
        drive(8'h0C, 10, 1'b0, 1'b0, '0);
        cmp("thr_drop_rise", 32'(rise_o), 32'h04);
        cmp("thr_drop_gpio", 32'(gpio_o), 32'h0C);
        run(8'h0C, 10, 4);

        // Bits 1 and 6 together with T=2.
        run(8'h00, 0, S + 3);
        idx = -1; rv = '0; nc = 0;
        for (int i = 0; i < 8; i++) begin
            drive(8'h42, 2, 1'b0, 1'b0, '0);
            if (rise_o != 8'h00 && idx < 0) begin
                idx = i;
                rv  = rise_o;
            end
            nc += int'(change_o);
        end
        cmp("simul_idx", 32'(idx), 32'(S + 2));
        cmp("simul_rise", 32'(rv), 32'h42);
        cmp("simul_change_cycles", 32'(nc), 32'd1);

        // Reset at count 30 with T=50, then full re-qualification.
        run(8'h00, 0, S + 3);
        run(8'h01, 50, S + 30);
        cmp("rmc_cnt30", 32'(dut.g_bit[0].u_bit.r_cnt), 32'd30);
        PRESET = 1'b1;
        #1;
        cmp("rmc_async_cnt", 32'(dut.g_bit[0].u_bit.r_cnt), 32'd0);
        cmp("rmc_async_gpio", 32'(gpio_o), 32'h0);
        for (int i = 0; i < 2; i++) drive(8'h01, 50, 1'b1, 1'b0, '0);
        idx = -1;
        for (int i = 0; i < 60; i++) begin
            drive(8'h01, 50, 1'b0, 1'b0, '0);
            if (gpio_o[0] && idx < 0) idx = i;
        end
        cmp("rmc_requal_idx", 32'(idx), 32'(S + 50));
        cmp("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/peripheral_gpio_debounce.md
# peripheral_gpio_debounce

Per-bit input conditioner placed directly upstream of the APB4 GPIO peripheral's `gpio_i` port. It synchronises asynchronous pad inputs into the `PCLK` domain and filters glitches with a programmable stability counter. It drives the debounced level into the GPIO block and emits single-cycle rise and fall pulses for each bit. It has no bus interface; `threshold_i` is driven by a static strap or by a register in the enclosing subsystem.

## Interface
Parameters:
- `PDATA_SIZE`, 8: number of GPIO bits; matches the downstream GPIO peripheral.
- `CNT_SIZE`, 16: width of the per-bit stability counter and of `threshold_i`.

Ports:
- `PCLK`  in  1  single clock; all state is on the rising edge.
- `PRESET`  in  1  reset, asynchronous and active-high.
- `pad_i`  in  PDATA_SIZE  raw asynchronous pad inputs.
- `threshold_i`  in  CNT_SIZE  required stable cycles T; sampled every cycle.
- `gpio_o`  out  PDATA_SIZE  debounced level; connects to GPIO `gpio_i`.
- `rise_o`  out  PDATA_SIZE  one-cycle pulse when a bit of `gpio_o` goes 0→1.
- `fall_o`  out  PDATA_SIZE  one-cycle pulse when a bit of `gpio_o` goes 1→0.
- `change_o`  out  1  OR-reduction of `rise_o | fall_o`, registered with them.

## Operation
- Reset: while `PRESET` is high, all synchroniser flops, `gpio_o`, every counter, `rise_o`, `fall_o` and `change_o` are cleared to 0 asynchronously.
- Synchroniser: each bit passes through an S-stage flop chain. S is 2 by default and 3 with the macro. The last stage is `sync`.
- Each bit is an independent two-state machine:
  - STABLE: `sync == gpio_o`. The counter is held at 0.
  - PENDING: `sync != gpio_o`.
- Per cycle in PENDING:
  - If `cnt >= threshold_i`: `gpio_o <= sync`, `cnt <= 0`, and the matching `rise_o`/`fall_o` bit is set for exactly one cycle.
  - Otherwise `cnt <= cnt + 1`.
- Glitch rejection: if `sync` returns to equal `gpio_o` before the update, the bit goes back to STABLE, the counter clears to 0 and no pulse is produced.
- `threshold_i` = 0: the bit passes through with one cycle of filter latency.
- The counter never exceeds `threshold_i`. It cannot wrap because the comparison is `>=`.
- Lowering `threshold_i` mid-count: any bit with `cnt >=` the new value updates on the next edge.
- Raising `threshold_i` mid-count: the bit keeps counting toward the new value.
- Simultaneous events across bits: each bit is handled independently. Several bits may pulse in the same cycle, and `change_o` is then a single-cycle high.
- Reset mid-count: the count is lost, `gpio_o` returns to 0, and after release a pad held at 1 is re-qualified from count 0.

## Timing
- Latency: a pad level that is stable from rising edge 1 onward appears on `gpio_o` after rising edge S+T+1.
- `rise_o`, `fall_o` and `change_o` assert in the same cycle that `gpio_o` changes, and deassert on the next edge.
- Minimum pulse width: a pad pulse shorter than T+1 `PCLK` cycles, as seen at `sync`, is fully rejected.
- All outputs are registered. There is no combinational path from any input to any output.

## Configuration
- `PERIPHERAL_GPIO_DEBOUNCE_SYNC3_EN`
  - Defined: 3-stage synchroniser (S=3), for pads with slow or noisy edges. All latencies grow by one cycle.
  - Undefined: 2-stage synchroniser (S=2).
- Counter and filter behaviour is identical in both cases.

## Structure
- Package `peripheral_gpio_debounce_pkg`:
  - `SYNC_STAGES`, derived from the macro.
  - Default `CNT_SIZE`.
  - Typedef `dbnc_state_t` with states STABLE and PENDING.
- Sub-module `peripheral_gpio_debounce_bit`: synchroniser chain, counter, state and edge pulses for one bit.
- Top level: a generate loop of `PDATA_SIZE` instances of `peripheral_gpio_debounce_bit`, plus the registered `change_o` OR.

## Test plan
- Reset value: assert `PRESET` with `pad_i=8'hFF` → all outputs 0. Release with T=4 → `gpio_o=8'hFF` after edge 7 (S=2), `rise_o=8'hFF` for one cycle, `change_o` high for one cycle.
- Glitch: T=4; pad bit0 is high for 3 cycles, then low → `gpio_o[0]` stays 0, no pulses, counter returns to 0.
- Pass-through: T=0; toggle `pad_i[3]` every 4 cycles → `gpio_o[3]` follows with a 3-cycle lag (S=2) and alternates `rise_o`/`fall_o` pulses.
- Threshold change: T=100; after the counter reaches 20, set T=10 → `gpio_o` updates on the next edge with one pulse.
- Simultaneous bits: bits 1 and 6 go high on the same edge with T=2 → both update on edge 5, `rise_o=8'h42`, `change_o` single-cycle.
- Reset mid-count: T=50; assert `PRESET` at count 30 with the pad held high → `gpio_o` stays 0. After release it updates after edge 53.
